serial_deserializer: RTL and testbench

- Downstream stage of the sequence-detecting serial transmitter; consumes its serOut/serOutValid bit stream.
- Samples one bit per single-cycle enable pulse (from the push-button one-pulser) and assembles WORD_W-bit words.
- Emits each completed word in parallel with a 1-cycle valid strobe.
- Keeps a 4-bit completed-word count suitable for the existing seven-segment decoder.

---
 rtl/serial_pkg.sv | 20 ++
 rtl/serial_deserializer.sv | 181 ++++++++++++++++++
 tb/tb_serial_deserializer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared constants for the serial deserializer: FSM encoding, counter width, default word size.
// PARITY is only reachable when SERIAL_DESERIALIZER_PARITY_EN is defined.
package serial_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SHIFT  = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;

  // Width of the counters fed to the seven-segment decoder.
  localparam int unsigned COUNT_W = 4;

  localparam int unsigned WORD_W_DEF = 8;

  typedef enum logic [1:0] {
    StIdle   = IDLE,
    StShift  = SHIFT,
    StParity = PARITY
  } state_e;

endpackage

// File: rtl/serial_deserializer.sv
// Collects WORD_W serial bits, one per bitEn pulse, and emits completed words with a valid strobe.
// Optional even-parity trailer bit enabled by defining SERIAL_DESERIALIZER_PARITY_EN.
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int unsigned WORD_W    = WORD_W_DEF,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bitEn,
  input  logic               serIn,
  input  logic               serInValid,
  output logic [WORD_W-1:0]  wordOut,
  output logic               wordValid,
  output logic               frameErr,
  output logic               parityErr,
  output logic [COUNT_W-1:0] bitCount,
  output logic [COUNT_W-1:0] wordCount
);

  localparam logic [COUNT_W-1:0] LastBit = COUNT_W'(WORD_W - 1);

  state_e state_q, state_d;

  logic [WORD_W-1:0]  sh_q, sh_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [WORD_W-1:0]  shifted;
  logic [COUNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [COUNT_W-1:0] word_cnt_q, word_cnt_d;
  logic               word_valid_q, word_valid_d;
  logic               frame_err_q, frame_err_d;
  logic               parity_err_q, parity_err_d;
  logic               sample, drop, last_bit;

  assign sample   = bitEn & serInValid;
  assign drop     = bitEn & ~serInValid;
  assign last_bit = (bit_cnt_q == LastBit);

  if (MSB_FIRST) begin : g_msb_first
    assign shifted = {sh_q[WORD_W-2:0], serIn};
  end else begin : g_lsb_first
    assign shifted = {serIn, sh_q[WORD_W-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (sample) begin
          state_d = StShift;
        end
      end
      StShift: begin
        if (drop) begin
          state_d = StIdle;
        end else if (sample && last_bit) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
          state_d = StParity;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      StParity: begin
        if (bitEn) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Datapath and pulse outputs.
  always_comb begin
    sh_d         = sh_q;
    word_d       = word_q;
    bit_cnt_d    = bit_cnt_q;
    word_cnt_d   = word_cnt_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (sample) begin
          sh_d      = shifted;
          bit_cnt_d = COUNT_W'(1);
        end
      end
      StShift: begin
        if (sample) begin
          sh_d = shifted;
          if (last_bit) begin
`ifdef SERIAL_DESERIALIZER_PARITY_EN
            bit_cnt_d    = bit_cnt_q + COUNT_W'(1);
`else
            word_d       = shifted;
            word_valid_d = 1'b1;
            word_cnt_d   = word_cnt_q + COUNT_W'(1);
            bit_cnt_d    = '0;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + COUNT_W'(1);
          end
        end else if (drop) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          sh_d        = '0;
        end
      end
`ifdef SERIAL_DESERIALIZER_PARITY_EN
      StParity: begin
        if (sample) begin
          word_d       = sh_q;
          word_valid_d = 1'b1;
          word_cnt_d   = word_cnt_q + COUNT_W'(1);
          bit_cnt_d    = '0;
          // Even parity: data plus parity bit must have an even number of ones.
          parity_err_d = ^{sh_q, serIn};
        end else if (drop) begin
          frame_err_d = 1'b1;
          bit_cnt_d   = '0;
          sh_d        = '0;
        end
      end
`endif
      default: begin
        sh_d      = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_q         <= '0;
      word_q       <= '0;
      bit_cnt_q    <= '0;
      word_cnt_q   <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      sh_q         <= sh_d;
      word_q       <= word_d;
      bit_cnt_q    <= bit_cnt_d;
      word_cnt_q   <= word_cnt_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign wordOut   = word_q;
  assign wordValid = word_valid_q;
  assign frameErr  = frame_err_q;
  assign bitCount  = bit_cnt_q;
  assign wordCount = word_cnt_q;

`ifdef SERIAL_DESERIALIZER_PARITY_EN
  assign parityErr = parity_err_q;
`else
  assign parityErr = 1'b0;

  logic unused_parity;
  assign unused_parity = parity_err_q ^ parity_err_d;
`endif

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench: two instances (MSB-first and LSB-first) fed the same bit stream.
module tb_serial_deserializer;
  import serial_pkg::*;

  localparam int unsigned W = 8;
`ifdef SERIAL_DESERIALIZER_PARITY_EN
  localparam bit ParityOn = 1'b1;
`else
  localparam bit ParityOn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic bitEn = 1'b0;
  logic serIn = 1'b0;
  logic serInValid = 1'b0;

  logic [W-1:0]       word_msb, word_lsb;
  logic               valid_msb, valid_lsb, ferr_msb, ferr_lsb, perr_msb, perr_lsb;
  logic [COUNT_W-1:0] bcnt_msb, bcnt_lsb, wcnt_msb, wcnt_lsb;

  typedef struct packed {
    logic [W-1:0] msb;
    logic [W-1:0] lsb;
    logic         perr;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           failures = 0;
  int           n_valid = 0;
  int           n_frame = 0;
  int           base;
  logic [3:0]   mon_cnt = '0;
  logic [3:0]   wcnt_exp;

  always #5 clk = ~clk;

  serial_deserializer #(.WORD_W(W), .MSB_FIRST(1'b1)) u_msb (
    .clk       (clk),
    .rst       (rst),
    .bitEn     (bitEn),
    .serIn     (serIn),
    .serInValid(serInValid),
    .wordOut   (word_msb),
    .wordValid (valid_msb),
    .frameErr  (ferr_msb),
    .parityErr (perr_msb),
    .bitCount  (bcnt_msb),
    .wordCount (wcnt_msb)
  );

  serial_deserializer #(.WORD_W(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk       (clk),
    .rst       (rst),
    .bitEn     (bitEn),
    .serIn     (serIn),
    .serInValid(serInValid),
    .wordOut   (word_lsb),
    .wordValid (valid_lsb),
    .frameErr  (ferr_lsb),
    .parityErr (perr_lsb),
    .bitCount  (bcnt_lsb),
    .wordCount (wcnt_lsb)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] v);
    logic [W-1:0] r;
    for (int i = 0; i < int'(W); i++) r[i] = v[W-1-i];
    return r;
  endfunction

  task automatic send_bit(input logic v, input logic d);
    @(negedge clk);
    bitEn      = 1'b1;
    serInValid = v;
    serIn      = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bitEn      = 1'b0;
      serInValid = 1'($urandom_range(0, 1));
      serIn      = 1'($urandom_range(0, 1));
    end
  endtask

  // Bits go out MSB first; the LSB-first instance therefore sees the reversed word.
  task automatic send_word(input logic [W-1:0] w, input logic flip);
    exp_t e;
    e.msb  = w;
    e.lsb  = rev(w);
    e.perr = flip & ParityOn;
    for (int i = int'(W) - 1; i >= 1; i--) send_bit(1'b1, w[i]);
`ifdef SERIAL_DESERIALIZER_PARITY_EN
    send_bit(1'b1, w[0]);
    sb.push_back(e);
    send_bit(1'b1, (^w) ^ flip);
`else
    sb.push_back(e);
    send_bit(1'b1, w[0]);
`endif
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (valid_msb) begin
        n_valid++;
        mon_cnt++;
        check_eq("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check_eq("word_msb", word_msb, mon_e.msb);
          check_eq("word_lsb", word_lsb, mon_e.lsb);
          check_eq("parity_err", perr_msb, mon_e.perr);
        end
        check_eq("valid_lsb", valid_lsb, 1);
        check_eq("word_cnt", wcnt_msb, mon_cnt);
      end
      if (ferr_msb) n_frame++;
    end
  end

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_word", word_msb, 0);
    check_eq("rst_bcnt", bcnt_msb, 0);
    check_eq("rst_wcnt", wcnt_msb, 0);
    check_eq("rst_valid", valid_msb, 0);
    check_eq("rst_ferr", ferr_msb, 0);
    check_eq("rst_perr", perr_msb, 0);
    rst = 1'b1;
    idle(2);

    // Basic word: bits 1,0,1,1,0,0,1,0.
    send_word(8'hB2, 1'b0);
    idle(1);
    check_eq("latency_valid", valid_msb, 1);
    check_eq("done_bcnt", bcnt_msb, 0);
    check_eq("done_wcnt", wcnt_msb, 1);
    idle(1);
    check_eq("valid_one_cycle", valid_msb, 0);
    check_eq("word_b2", word_msb, 8'hB2);
    check_eq("word_4d", word_lsb, 8'h4D);

    // Abort after 3 bits.
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    idle(1);
    check_eq("partial_bcnt", bcnt_msb, 3);
    send_bit(1'b0, 1'b1);
    idle(1);
    check_eq("abort_ferr", ferr_msb, 1);
    check_eq("abort_bcnt", bcnt_msb, 0);
    check_eq("abort_word", word_msb, 8'hB2);
    check_eq("abort_wcnt", wcnt_msb, 1);
    idle(1);
    check_eq("ferr_one_cycle", ferr_msb, 0);

`ifdef SERIAL_DESERIALIZER_PARITY_EN
    send_word(8'hB2, 1'b0);
    idle(1);
    check_eq("par_ok_valid", valid_msb, 1);
    check_eq("par_ok_perr", perr_msb, 0);
    send_word(8'hB2, 1'b1);
    idle(1);
    check_eq("par_bad_valid", valid_msb, 1);
    check_eq("par_bad_perr", perr_msb, 1);
    check_eq("par_bad_word", word_msb, 8'hB2);
    idle(1);
`endif

    // Back-to-back words through the wordCount wrap.
    base     = n_valid;
    wcnt_exp = wcnt_msb;
    for (int k = 0; k < 17; k++) send_word(8'h00, 1'b0);
    idle(2);
    check_eq("burst_pulses", n_valid - base, 17);
    wcnt_exp = wcnt_exp + 4'd1;
    check_eq("burst_wcnt", wcnt_msb, 32'(wcnt_exp));

    // Hold with bitEn low mid-word, then asynchronous reset.
    base     = n_valid;
    wcnt_exp = wcnt_msb;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    idle(50);
    check_eq("hold_bcnt", bcnt_msb, 4);
    check_eq("hold_word", word_msb, 8'h00);
    check_eq("hold_wcnt", wcnt_msb, 32'(wcnt_exp));
    check_eq("hold_pulses", n_valid - base, 0);
    send_bit(1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    check_eq("arst_word", word_msb, 0);
    check_eq("arst_bcnt", bcnt_msb, 0);
    check_eq("arst_wcnt", wcnt_msb, 0);
    check_eq("arst_valid", valid_msb, 0);
    check_eq("arst_ferr", ferr_msb, 0);
    bitEn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("arst_no_pulse", {valid_msb, ferr_msb, perr_msb}, 0);
    mon_cnt = '0;
    rst     = 1'b1;
    idle(1);

    send_word(8'h5A, 1'b0);
    idle(2);
    check_eq("post_rst_word", word_msb, 8'h5A);
    check_eq("post_rst_wcnt", wcnt_msb, 1);
    check_eq("sb_drained", sb.size(), 0);
    check_eq("frame_pulses", n_frame, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
